// File: rtl/alarm_timebase.sv
// alarm_timebase
// ---------------------------------------------------------------------------
// Timebase and latency-counter stage for the home alarm controller.
// Divides the reference clock into a free-running 1 Hz blink clock and runs
// two independent second counters. P2 is the arming latency and P1 is the
// re-arm latency. Each channel asserts a held "count complete" level while
// its enable stays high.
//
// Parameters:
//   CLK_HZ      reference clock cycles per second (>= 2)
//   P2_SECONDS  P2 channel duration in seconds (1..15)
//   P1_SECONDS  P1 channel duration in seconds (1..15)
//
// Ports:
//   CLOCK_IN         in   reference clock, all state on its rising edge
//   RESET_N          in   asynchronous active-low reset
//   ENABLE_COUNT_P2  in   level: high runs the P2 channel, low clears it
//   ENABLE_COUNT_P1  in   level: high runs the P1 channel, low clears it
//   CLOCK_1          out  registered 1 Hz blink clock
//   COUNT_OUT_P2     out  registered P2 count-complete level
//   COUNT_OUT_P1     out  registered P1 count-complete level
//   REMAIN_SEC[3:0]  out  seconds left on the active channel (optional)
//
// Optional feature macro: ALARM_TIMEBASE_REMAIN_EN
//   When defined, the REMAIN_SEC port and its register are built.
//   P1 takes display priority over P2.
// ---------------------------------------------------------------------------
module alarm_timebase #(
    parameter int CLK_HZ     = 50000000,
    parameter int P2_SECONDS = 5,
    parameter int P1_SECONDS = 10
) (
    input  logic       CLOCK_IN,
    input  logic       RESET_N,
    input  logic       ENABLE_COUNT_P2,
    input  logic       ENABLE_COUNT_P1,
    output logic       CLOCK_1,
    output logic       COUNT_OUT_P2,
    output logic       COUNT_OUT_P1
`ifdef ALARM_TIMEBASE_REMAIN_EN
    ,
    output logic [3:0] REMAIN_SEC
`endif
);

    localparam int              CW      = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CW-1:0]   SUB_MAX = CW'(CLK_HZ - 1);
    localparam logic [CW-1:0]   HALF    = CW'(CLK_HZ / 2);
    localparam logic [3:0]      P2_LIM  = 4'(P2_SECONDS);
    localparam logic [3:0]      P1_LIM  = 4'(P1_SECONDS);
    // Index 0 is the P2 channel, index 1 is the P1 channel.
    localparam logic [1:0][3:0] SEC_LIM = {P1_LIM, P2_LIM};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COUNTING,
        ST_DONE
    } chan_state_t;

    logic [CW-1:0]       blink_q;
    logic [CW-1:0]       blink_d;

    logic [1:0]          enable;
    chan_state_t         state_q [2];
    chan_state_t         state_d [2];
    logic [1:0][CW-1:0]  sub_q;
    logic [1:0][CW-1:0]  sub_d;
    logic [1:0][3:0]     sec_q;
    logic [1:0][3:0]     sec_d;

    assign enable = {ENABLE_COUNT_P1, ENABLE_COUNT_P2};

    // Blink divider: wraps 0..CLK_HZ-1 and ignores both enables.
    always_comb begin
        blink_d = blink_q + CW'(1);
        if (blink_q == SUB_MAX) begin
            blink_d = '0;
        end
    end

    // CLOCK_1 is derived from the next divider value so that it is high on
    // the edge where the divider wraps to 0. This keeps it consistent with
    // the reset value, where the divider is 0 and CLOCK_1 is 1.
    always_ff @(posedge CLOCK_IN or negedge RESET_N) begin
        if (!RESET_N) begin
            blink_q <= '0;
            CLOCK_1 <= 1'b1;
        end else begin
            blink_q <= blink_d;
            CLOCK_1 <= (blink_d < HALF);
        end
    end

    // Channel next-state logic. An IDLE channel that samples its enable high
    // already counts that edge as its first cycle, so the shared increment
    // path covers both IDLE and COUNTING. Any edge with the enable low
    // returns the channel to a clean IDLE, so there is no pause/resume.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            state_d[i] = state_q[i];
            sub_d[i]   = sub_q[i];
            sec_d[i]   = sec_q[i];
            if (!enable[i]) begin
                state_d[i] = ST_IDLE;
                sub_d[i]   = '0;
                sec_d[i]   = '0;
            end else if (state_q[i] != ST_DONE) begin
                state_d[i] = ST_COUNTING;
                if (sub_q[i] == SUB_MAX) begin
                    sub_d[i] = '0;
                    sec_d[i] = sec_q[i] + 4'd1;
                    if ((sec_q[i] + 4'd1) == SEC_LIM[i]) begin
                        state_d[i] = ST_DONE;
                    end
                end else begin
                    sub_d[i] = sub_q[i] + CW'(1);
                end
            end
        end
    end

    // Channel registers. Each count-complete level is registered from the
    // next state, so it rises on the same edge the channel enters DONE.
    always_ff @(posedge CLOCK_IN or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= ST_IDLE;
                sub_q[i]   <= '0;
                sec_q[i]   <= '0;
            end
            COUNT_OUT_P2 <= 1'b0;
            COUNT_OUT_P1 <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= state_d[i];
                sub_q[i]   <= sub_d[i];
                sec_q[i]   <= sec_d[i];
            end
            COUNT_OUT_P2 <= (state_d[0] == ST_DONE);
            COUNT_OUT_P1 <= (state_d[1] == ST_DONE);
        end
    end

`ifdef ALARM_TIMEBASE_REMAIN_EN
    logic [3:0] remain_d;

    // Remaining seconds on the channel the display follows. P1 wins when
    // both are enabled. Only a channel that is still counting shows a
    // nonzero value. Working from next-state values makes the display read
    // the full duration on the first enabled edge.
    always_comb begin
        remain_d = '0;
        if (ENABLE_COUNT_P1) begin
            if (state_d[1] == ST_COUNTING) begin
                remain_d = SEC_LIM[1] - sec_d[1];
            end
        end else if (ENABLE_COUNT_P2) begin
            if (state_d[0] == ST_COUNTING) begin
                remain_d = SEC_LIM[0] - sec_d[0];
            end
        end
    end

    // Registered remaining-seconds display.
    always_ff @(posedge CLOCK_IN or negedge RESET_N) begin
        if (!RESET_N) begin
            REMAIN_SEC <= '0;
        end else begin
            REMAIN_SEC <= remain_d;
        end
    end
`endif

endmodule

// File: tb/tb_alarm_timebase.sv
// tb_alarm_timebase
// ---------------------------------------------------------------------------
// Scoreboard bench for alarm_timebase with CLK_HZ=10, P2=5 s, P1=10 s.
// The stimulus process drives inputs just after a rising edge and queues
// expected output values tagged with the absolute edge number they refer to.
// A monitor samples on each falling edge and retires every queued entry
// whose edge has arrived. Edges are counted from simulation start.
// ---------------------------------------------------------------------------
module tb_alarm_timebase;

    localparam int SIG_CLK1   = 0;
    localparam int SIG_P2     = 1;
    localparam int SIG_P1     = 2;
    localparam int SIG_REMAIN = 3;

    typedef struct {
        int         at_edge;
        int         sig;
        logic [3:0] value;
        string      name;
    } exp_t;

    logic clock_in;
    logic reset_n;
    logic enable_count_p2;
    logic enable_count_p1;
    logic clock_1;
    logic count_out_p2;
    logic count_out_p1;
`ifdef ALARM_TIMEBASE_REMAIN_EN
    logic [3:0] remain_sec;
`endif

    exp_t exp_q[$];
    int   edge_cnt    = 0;
    int   vectors     = 0;
    int   miscompares = 0;

    alarm_timebase #(
        .CLK_HZ    (10),
        .P2_SECONDS(5),
        .P1_SECONDS(10)
    ) dut (
        .CLOCK_IN       (clock_in),
        .RESET_N        (reset_n),
        .ENABLE_COUNT_P2(enable_count_p2),
        .ENABLE_COUNT_P1(enable_count_p1),
        .CLOCK_1        (clock_1),
        .COUNT_OUT_P2   (count_out_p2),
        .COUNT_OUT_P1   (count_out_p1)
`ifdef ALARM_TIMEBASE_REMAIN_EN
        ,
        .REMAIN_SEC     (remain_sec)
`endif
    );

    // Reference clock.
    initial begin
        clock_in = 1'b0;
        forever #5 clock_in = ~clock_in;
    end

    // Absolute rising-edge counter used to tag expectations.
    always @(posedge clock_in) begin
        edge_cnt <= edge_cnt + 1;
    end

    task automatic applyStimulus(input logic rst_n, input logic en_p2, input logic en_p1);
        reset_n         = rst_n;
        enable_count_p2 = en_p2;
        enable_count_p1 = en_p1;
    endtask

    task automatic expectAt(input int at, input int sig, input logic [3:0] val, input string name);
        exp_t e;
        e.at_edge = at;
        e.sig     = sig;
        e.value   = val;
        e.name    = name;
        exp_q.push_back(e);
    endtask

    // Advance to 1 time unit after the given edge.
    task automatic waitTo(input int target);
        while (edge_cnt < target) begin
            @(posedge clock_in);
            #1;
        end
    endtask

    function automatic logic [3:0] sampleSig(input int sig);
        logic [3:0] v;
        v = 4'd0;
        case (sig)
            SIG_CLK1:   v = {3'b000, clock_1};
            SIG_P2:     v = {3'b000, count_out_p2};
            SIG_P1:     v = {3'b000, count_out_p1};
`ifdef ALARM_TIMEBASE_REMAIN_EN
            SIG_REMAIN: v = remain_sec;
`endif
            default:    v = 4'd0;
        endcase
        return v;
    endfunction

    task automatic checkOutput(input string name, input int at, input logic [3:0] actual,
                               input logic [3:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s @edge %0d: got %0d, expected %0d", name, at, actual, expected);
        end
    endtask

    // Monitor: retire every expectation whose edge has been reached.
    always @(negedge clock_in) begin
        int i;
        i = 0;
        while (i < exp_q.size()) begin
            if (exp_q[i].at_edge <= edge_cnt) begin
                checkOutput(exp_q[i].name, exp_q[i].at_edge, sampleSig(exp_q[i].sig), exp_q[i].value);
                exp_q.delete(i);
            end else begin
                i++;
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int k;
        int r;

        // ---------------- Reset, then idle blink check ----------------
        applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clock_in);
        #1;
        r = edge_cnt;
        expectAt(r, SIG_CLK1, 4'd1, "reset_clock_1");
        expectAt(r, SIG_P2,   4'd0, "reset_p2");
        expectAt(r, SIG_P1,   4'd0, "reset_p1");
`ifdef ALARM_TIMEBASE_REMAIN_EN
        expectAt(r, SIG_REMAIN, 4'd0, "reset_remain");
`endif
        applyStimulus(1'b1, 1'b0, 1'b0);
        // Blink cycle n lands on edge r+n: high for n mod 10 in 0..4.
        for (int n = 1; n <= 20; n++) begin
            expectAt(r + n, SIG_CLK1, ((n % 10) < 5) ? 4'd1 : 4'd0, "blink");
        end
        for (int j = 1; j <= 8; j++) begin
            expectAt(r + 25 * j, SIG_P2, 4'd0, "idle_p2");
            expectAt(r + 25 * j, SIG_P1, 4'd0, "idle_p1");
        end
        waitTo(r + 200);

        // ---------------- P2 alone held high ----------------
        k = edge_cnt;
        applyStimulus(1'b1, 1'b1, 1'b0);
        expectAt(k + 49, SIG_P2, 4'd0, "p2_before_50");
        expectAt(k + 50, SIG_P2, 4'd1, "p2_at_50");
        expectAt(k + 60, SIG_P2, 4'd1, "p2_held");
        expectAt(k + 60, SIG_P1, 4'd0, "p1_quiet");
        expectAt(k + 61, SIG_P2, 4'd0, "p2_clear");
`ifdef ALARM_TIMEBASE_REMAIN_EN
        expectAt(k + 1,  SIG_REMAIN, 4'd5, "remain_p2_e1");
        expectAt(k + 9,  SIG_REMAIN, 4'd5, "remain_p2_e9");
        expectAt(k + 10, SIG_REMAIN, 4'd4, "remain_p2_e10");
        expectAt(k + 20, SIG_REMAIN, 4'd3, "remain_p2_e20");
        expectAt(k + 30, SIG_REMAIN, 4'd2, "remain_p2_e30");
        expectAt(k + 40, SIG_REMAIN, 4'd1, "remain_p2_e40");
        expectAt(k + 49, SIG_REMAIN, 4'd1, "remain_p2_e49");
        expectAt(k + 50, SIG_REMAIN, 4'd0, "remain_p2_done");
`endif
        waitTo(k + 60);
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitTo(k + 61);

        // ---------------- P1 with a one-cycle enable drop ----------------
        k = edge_cnt;
        applyStimulus(1'b1, 1'b0, 1'b1);
        expectAt(k + 40,  SIG_P1, 4'd0, "p1_mid");
        expectAt(k + 100, SIG_P1, 4'd0, "p1_old_edge_100");
        expectAt(k + 140, SIG_P1, 4'd0, "p1_before_restart_100");
        expectAt(k + 141, SIG_P1, 4'd1, "p1_restart_100");
        expectAt(k + 142, SIG_P1, 4'd0, "p1_clear");
`ifdef ALARM_TIMEBASE_REMAIN_EN
        expectAt(k + 40, SIG_REMAIN, 4'd6,  "remain_p1_e40");
        expectAt(k + 41, SIG_REMAIN, 4'd0,  "remain_p1_dropped");
        expectAt(k + 42, SIG_REMAIN, 4'd10, "remain_p1_restart");
`endif
        waitTo(k + 40);
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitTo(k + 41);
        applyStimulus(1'b1, 1'b0, 1'b1);
        waitTo(k + 141);
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitTo(k + 142);

        // ---------------- Both enables raised together ----------------
        k = edge_cnt;
        applyStimulus(1'b1, 1'b1, 1'b1);
        expectAt(k + 49,  SIG_P2, 4'd0, "both_p2_49");
        expectAt(k + 50,  SIG_P2, 4'd1, "both_p2_50");
        expectAt(k + 50,  SIG_P1, 4'd0, "both_p1_50");
        expectAt(k + 99,  SIG_P1, 4'd0, "both_p1_99");
        expectAt(k + 100, SIG_P1, 4'd1, "both_p1_100");
        expectAt(k + 100, SIG_P2, 4'd1, "both_p2_held");
        expectAt(k + 101, SIG_P2, 4'd0, "both_p2_clear");
        expectAt(k + 101, SIG_P1, 4'd0, "both_p1_clear");
`ifdef ALARM_TIMEBASE_REMAIN_EN
        expectAt(k + 1,   SIG_REMAIN, 4'd10, "remain_both_e1");
        expectAt(k + 50,  SIG_REMAIN, 4'd5,  "remain_both_e50");
        expectAt(k + 100, SIG_REMAIN, 4'd0,  "remain_both_done");
`endif
        waitTo(k + 100);
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitTo(k + 101);

        // ---------------- Reset pulse mid-count ----------------
        // P2 starts first, P1 joins 20 edges later; P1 enabled edge 30 is
        // k+50, where P2 has just completed. Reset is asserted after that edge.
        k = edge_cnt;
        applyStimulus(1'b1, 1'b1, 1'b0);
        expectAt(k + 49,  SIG_P2,   4'd0, "rst_p2_49");
        expectAt(k + 50,  SIG_P2,   4'd0, "rst_async_p2");
        expectAt(k + 50,  SIG_P1,   4'd0, "rst_async_p1");
        expectAt(k + 50,  SIG_CLK1, 4'd1, "rst_async_clock_1");
        expectAt(k + 55,  SIG_CLK1, 4'd1, "rst_blink_c4");
        expectAt(k + 56,  SIG_CLK1, 4'd0, "rst_blink_c5");
        expectAt(k + 60,  SIG_CLK1, 4'd0, "rst_blink_c9");
        expectAt(k + 61,  SIG_CLK1, 4'd1, "rst_blink_c10");
        expectAt(k + 100, SIG_P2,   4'd0, "rst_p2_before");
        expectAt(k + 101, SIG_P2,   4'd1, "rst_p2_after");
        expectAt(k + 150, SIG_P1,   4'd0, "rst_p1_before");
        expectAt(k + 151, SIG_P1,   4'd1, "rst_p1_after");
        expectAt(k + 152, SIG_P2,   4'd0, "final_p2_clear");
        expectAt(k + 152, SIG_P1,   4'd0, "final_p1_clear");
`ifdef ALARM_TIMEBASE_REMAIN_EN
        expectAt(k + 20, SIG_REMAIN, 4'd3,  "remain_p2_before_p1");
        expectAt(k + 21, SIG_REMAIN, 4'd10, "remain_switch_to_p1");
        expectAt(k + 45, SIG_REMAIN, 4'd8,  "remain_p1_e25");
        expectAt(k + 50, SIG_REMAIN, 4'd0,  "remain_async_reset");
        expectAt(k + 52, SIG_REMAIN, 4'd10, "remain_after_release");
`endif
        waitTo(k + 20);
        applyStimulus(1'b1, 1'b1, 1'b1);
        waitTo(k + 50);
        applyStimulus(1'b0, 1'b1, 1'b1);
        waitTo(k + 51);
        applyStimulus(1'b1, 1'b1, 1'b1);
        waitTo(k + 151);
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitTo(k + 152);

        // Let the monitor drain, bounded; leftovers count as misses.
        for (int w = 0; w < 20 && exp_q.size() > 0; w++) begin
            @(posedge clock_in);
            #1;
        end
        while (exp_q.size() > 0) begin
            miscompares++;
            $display("[TB] FAIL unchecked %s @edge %0d: got none, expected %0d",
                     exp_q[0].name, exp_q[0].at_edge, exp_q[0].value);
            void'(exp_q.pop_front());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alarm_timebase.md
# alarm_timebase

Timebase and latency-counter stage feeding the home alarm controller. Divides the 50 MHz reference clock into a free-running 1 Hz blink clock. Runs two independently enabled second counters, 5 s arming latency and 10 s re-arm latency. Consumes the controller's counter-enable outputs and returns the count-complete levels it waits on.

## Interface
- CLK_HZ, 50000000, reference clock cycles per second; ≥2.
- P2_SECONDS, 5, duration of the P2 (arming latency) channel in seconds; 1–15.
- P1_SECONDS, 10, duration of the P1 (re-arm latency) channel in seconds; 1–15.

- CLOCK_IN  input  1  50 MHz reference clock; all state on its rising edge.
- RESET_N  input  1  reset, asynchronous, active-low.
- ENABLE_COUNT_P2  input  1  level; high runs P2 channel, low clears it.
- ENABLE_COUNT_P1  input  1  level; high runs P1 channel, low clears it.
- CLOCK_1  output  1  1 Hz blink clock, registered.
- COUNT_OUT_P2  output  1  P2 count complete, registered level.
- COUNT_OUT_P1  output  1  P1 count complete, registered level.
- REMAIN_SEC  output  4  seconds remaining on active channel; present only with ALARM_TIMEBASE_REMAIN_EN.

## Operation
- Blink divider: free-running cycle counter 0..CLK_HZ-1, wraps to 0. CLOCK_1 high while counter < CLK_HZ/2 (integer divide), else low. Unaffected by either enable.
- Each channel owns a sub-second counter (0..CLK_HZ-1) and a seconds counter (0..SECONDS). Channels are fully independent and never share the blink divider.
- Channel FSM states:
  - IDLE: counters 0, COUNT_OUT 0. ENABLE sampled high → COUNTING.
  - COUNTING: sub-second counter increments each cycle. On wrap it returns to 0 and seconds increments. ENABLE low → IDLE. Seconds reaching SECONDS → DONE.
  - DONE: COUNT_OUT 1, counters frozen. ENABLE low → IDLE.
- COUNT_OUT is a held level, not a pulse. It stays high until ENABLE is sampled low.
- Enable dropped mid-count aborts the count. Re-enable always restarts from zero; there is no pause/resume.
- Both enables high together: each channel times independently and may complete on the same edge.
- Counter widths: sub-second counter is ceil(log2(CLK_HZ)) bits; seconds counter is 4 bits. No overflow is possible within legal parameters.

## Timing
- Reset (RESET_N low, asynchronous): CLOCK_1=1, COUNT_OUT_P2=0, COUNT_OUT_P1=0, REMAIN_SEC=0. All counters 0 and both FSMs IDLE. The first edge after release is blink cycle 1.
- Count latency: the first rising edge that samples ENABLE high is edge 1. COUNT_OUT rises on edge SECONDS×CLK_HZ.
- Clear latency: COUNT_OUT falls on the first edge that samples ENABLE low.
- ENABLE low for a single cycle fully restarts the channel.
- Reset asserted mid-count: outputs clear immediately, without waiting for a clock edge. After release, a channel whose ENABLE is still high starts a full new count on the first edge.
- CLOCK_1: period CLK_HZ cycles, high for floor(CLK_HZ/2) cycles. It rises on the edge where the divider wraps to 0.

## Configuration
- ALARM_TIMEBASE_REMAIN_EN defined:
  - REMAIN_SEC port exists and is registered.
  - Value: SECONDS − completed seconds of P1 if ENABLE_COUNT_P1 is high; else that of P2 if ENABLE_COUNT_P2 is high; else 0.
  - Value is 0 in DONE or IDLE.
  - It updates on the same edge the seconds counter changes, and becomes SECONDS on the first enabled edge.
- Not defined: REMAIN_SEC port and its logic are absent; all other behaviour is identical.

## Test plan
All scenarios use CLK_HZ=10, P2_SECONDS=5, P1_SECONDS=10.
- Reset held, then released with enables low → CLOCK_1=1 and both COUNT_OUT=0 at reset; CLOCK_1 then has period 10 cycles with 5 high, and COUNT_OUT stays 0 for 200 cycles.
- ENABLE_COUNT_P2 held high → COUNT_OUT_P2 rises on enabled edge 50 and stays high; ENABLE low → COUNT_OUT_P2 low on the next edge.
- ENABLE_COUNT_P1 high 40 cycles, low 1 cycle, high again → COUNT_OUT_P1 stays low at the old edge 100 and rises exactly 100 edges after re-enable.
- Both enables raised on the same edge → COUNT_OUT_P2 rises at edge 50 and COUNT_OUT_P1 at edge 100, independently.
- RESET_N pulsed low at enabled edge 30 of P1 with ENABLE held high → outputs clear asynchronously; COUNT_OUT_P1 rises 100 edges after release.
- With ALARM_TIMEBASE_REMAIN_EN and P2 enabled → REMAIN_SEC reads 5,4,3,2,1 at 10-cycle steps, then 0 as COUNT_OUT_P2 rises; also raising P1 mid-count switches the display to the P1 value.
